// File: rtl/parity_pkg.sv
// Purpose : shared constants and helpers for the raw-hits RAM parity monitor.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package parity_pkg;

  localparam int PAR_NGRP    = 7;     // CFEB groups
  localparam int PAR_NLY     = 6;     // layer RAMs per group
  localparam int PAR_ARM_CNT = 4096;  // full FIFO address sweep before arming

  // Flat RAM index split into its group and layer.
  typedef struct packed {
    logic [15:0] grp;
    logic [15:0] ly;
  } ram_loc_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Flat index g*nly+l -> {g, l}.
  function automatic ram_loc_t ram_loc(input int unsigned idx, input int unsigned nly);
    ram_loc_t r;
    r.grp = 16'(idx / nly);
    r.ly  = 16'(idx % nly);
    return r;
  endfunction

endpackage

// File: rtl/parity_arm.sv
// Purpose : arms the parity monitor after ARM_CNT consecutive raw-hits FIFO writes.
// Latency : perr_en registers on the edge that samples the ARM_CNT-th write.
// Backpressure: none; fifo_wen is observed only, never stalled.
// Ports   : clock, clr (sync clear), fifo_wen in; perr_en out (sticky until clr).
module parity_arm
  import parity_pkg::*;
#(
  parameter int ARM_CNT = PAR_ARM_CNT
) (
  input  logic clock,
  input  logic clr,
  input  logic fifo_wen,
  output logic perr_en
);

  localparam int AW = (clog2(ARM_CNT + 1) < 1) ? 1 : clog2(ARM_CNT + 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CNT - 1);

  logic [AW-1:0] arm_cnt;

  // The run must be unbroken: any idle write cycle restarts it from zero.
  // Once armed the counter is parked at zero; only clr can disarm.
  always_ff @(posedge clock) begin
    if (clr) begin
      arm_cnt <= '0;
      perr_en <= 1'b0;
    end else if (perr_en) begin
      arm_cnt <= '0;
    end else if (fifo_wen) begin
      if (arm_cnt == ARM_LAST) begin
        arm_cnt <= '0;
        perr_en <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end else begin
      arm_cnt <= '0;
    end
  end

endmodule

// File: rtl/parity_monitor.sv
// Purpose : masks, summarises and latches per-RAM parity errors; counts and captures first error.
// Latency : perr_grp/perr combinational; pulse, latches, counter and first capture one cycle later.
// Backpressure: none; monitors every cycle, never stalls the hit path.
// Ports   : clock, reset, perr_clear, parity_err, ram_mask, fifo_wen in;
//           perr_grp, perr (live), perr_en, perr_pulse, perr_grp_ff, perr_ff,
//           perr_ram_ff, perr_cnt, first_valid, first_ram out.
module parity_monitor
  import parity_pkg::*;
#(
  parameter int NGRP    = PAR_NGRP,
  parameter int NLY     = PAR_NLY,
  parameter int ARM_CNT = PAR_ARM_CNT,
  parameter int CNTW    = 16,
  localparam int N      = NGRP * NLY,
  localparam int IDXW   = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            perr_clear,
  input  logic [N-1:0]    parity_err,
  input  logic [N-1:0]    ram_mask,
  input  logic            fifo_wen,
  output logic [NGRP-1:0] perr_grp,
  output logic            perr,
  output logic            perr_en,
  output logic            perr_pulse,
  output logic [NGRP-1:0] perr_grp_ff,
  output logic            perr_ff,
  output logic [N-1:0]    perr_ram_ff,
  output logic [CNTW-1:0] perr_cnt,
  output logic            first_valid,
  output logic [IDXW-1:0] first_ram
);

  logic           clr;
  logic [N-1:0]   merr;
  logic [IDXW-1:0] first_idx;
  logic           hit;

  assign clr  = reset | perr_clear;
  assign merr = parity_err & ~ram_mask;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign perr_grp[g] = |merr[g*NLY +: NLY];
  end

  assign perr = |perr_grp;

  parity_arm #(
    .ARM_CNT (ARM_CNT)
  ) u_arm (
    .clock    (clock),
    .clr      (clr),
    .fifo_wen (fifo_wen),
    .perr_en  (perr_en)
  );

  // Scan downward so the last assignment, and therefore the winner, is the lowest set index.
  always_comb begin
    first_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (merr[i]) first_idx = IDXW'(i);
    end
  end

  // Uses the registered perr_en: an error on the arming edge itself is not recorded.
  assign hit = perr & perr_en;

  always_ff @(posedge clock) begin
    if (clr) begin
      perr_pulse  <= 1'b0;
      perr_ram_ff <= '0;
      perr_grp_ff <= '0;
      perr_ff     <= 1'b0;
      perr_cnt    <= '0;
      first_valid <= 1'b0;
      first_ram   <= '0;
    end else begin
      perr_pulse <= hit;
      if (perr_en) begin
        perr_ram_ff <= perr_ram_ff | merr;
        perr_grp_ff <= perr_grp_ff | perr_grp;
        perr_ff     <= perr_ff | perr;
      end
      if (hit && (perr_cnt != {CNTW{1'b1}})) begin
        perr_cnt <= perr_cnt + 1'b1;
      end
      if (hit && !first_valid) begin
        first_valid <= 1'b1;
        first_ram   <= first_idx;
      end
    end
  end

endmodule

// File: tb/tb_parity_monitor.sv
// Purpose : scoreboard bench for parity_monitor with directed and random stimulus.
// Latency : expected values checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_parity_monitor;

  localparam int NGRP    = 7;
  localparam int NLY     = 6;
  localparam int ARM_CNT = 8;
  localparam int CNTW    = 4;
  localparam int N       = NGRP * NLY;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            perr_clear;
  logic [N-1:0]    parity_err;
  logic [N-1:0]    ram_mask;
  logic            fifo_wen;
  logic [NGRP-1:0] perr_grp;
  logic            perr;
  logic            perr_en;
  logic            perr_pulse;
  logic [NGRP-1:0] perr_grp_ff;
  logic            perr_ff;
  logic [N-1:0]    perr_ram_ff;
  logic [CNTW-1:0] perr_cnt;
  logic            first_valid;
  logic [5:0]      first_ram;

  always #5 clock = ~clock;

  parity_monitor #(
    .NGRP    (NGRP),
    .NLY     (NLY),
    .ARM_CNT (ARM_CNT),
    .CNTW    (CNTW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .perr_clear  (perr_clear),
    .parity_err  (parity_err),
    .ram_mask    (ram_mask),
    .fifo_wen    (fifo_wen),
    .perr_grp    (perr_grp),
    .perr        (perr),
    .perr_en     (perr_en),
    .perr_pulse  (perr_pulse),
    .perr_grp_ff (perr_grp_ff),
    .perr_ff     (perr_ff),
    .perr_ram_ff (perr_ram_ff),
    .perr_cnt    (perr_cnt),
    .first_valid (first_valid),
    .first_ram   (first_ram)
  );

  // One record per clock: live outputs for the inputs sampled at that edge,
  // plus the registered outputs that edge must produce.
  typedef struct {
    logic [NGRP-1:0] grp;
    logic            any;
    logic            en;
    logic            pulse;
    logic [NGRP-1:0] grp_ff;
    logic            ff;
    logic [N-1:0]    ram_ff;
    logic [CNTW-1:0] cnt;
    logic            fv;
    logic [5:0]      fr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  int checks = 0;
  int passes = 0;

  // Reference state: what the monitor should hold, tracked as plain values.
  logic            m_en     = 1'b0;
  logic            m_pulse  = 1'b0;
  logic [NGRP-1:0] m_grp_ff = '0;
  logic            m_ff     = 1'b0;
  logic [N-1:0]    m_ram    = '0;
  int              m_cnt    = 0;
  logic            m_fv     = 1'b0;
  int              m_fr     = 0;
  int              m_run    = 0;   // consecutive writes seen while unarmed

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end else begin
      passes++;
    end
  endtask

  function automatic logic [N-1:0] rnd_bits();
    return N'({$urandom(), $urandom()});
  endfunction

  // Applies the currently driven inputs to the reference, queues the expectation,
  // then lets one clock edge pass.
  task automatic cycle();
    logic [N-1:0]    merr;
    logic [NGRP-1:0] grp;
    logic            any;
    int              lowest;
    exp_t            e;
    merr = parity_err & ~ram_mask;
    for (int g = 0; g < NGRP; g++) grp[g] = |merr[g*NLY +: NLY];
    any = (merr != '0);
    lowest = -1;
    for (int i = 0; i < N; i++) begin
      if (merr[i] && lowest < 0) lowest = i;
    end
    if (reset || perr_clear) begin
      m_en = 1'b0; m_pulse = 1'b0; m_grp_ff = '0; m_ff = 1'b0; m_ram = '0;
      m_cnt = 0; m_fv = 1'b0; m_fr = 0; m_run = 0;
    end else begin
      m_pulse = any && m_en;
      if (m_en) begin
        m_ram    = m_ram | merr;
        m_grp_ff = m_grp_ff | grp;
        m_ff     = m_ff | any;
      end
      if (any && m_en) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!m_fv) begin
          m_fv = 1'b1;
          m_fr = lowest;
        end
      end
      if (!m_en) begin
        if (fifo_wen) begin
          m_run++;
          if (m_run == ARM_CNT) begin
            m_en  = 1'b1;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    e.grp = grp; e.any = any; e.en = m_en; e.pulse = m_pulse; e.grp_ff = m_grp_ff;
    e.ff = m_ff; e.ram_ff = m_ram; e.cnt = CNTW'(m_cnt); e.fv = m_fv; e.fr = 6'(m_fr);
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic drive(input logic rst, input logic pc, input logic wen,
                       input logic [N-1:0] err, input logic [N-1:0] mask);
    reset      = rst;
    perr_clear = pc;
    fifo_wen   = wen;
    parity_err = err;
    ram_mask   = mask;
    cycle();
  endtask

  // Monitor: compares DUT against the queued expectation after every edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        check("perr_grp",    64'(perr_grp),    64'(e_mon.grp));
        check("perr",        64'(perr),        64'(e_mon.any));
        check("perr_en",     64'(perr_en),     64'(e_mon.en));
        check("perr_pulse",  64'(perr_pulse),  64'(e_mon.pulse));
        check("perr_grp_ff", 64'(perr_grp_ff), 64'(e_mon.grp_ff));
        check("perr_ff",     64'(perr_ff),     64'(e_mon.ff));
        check("perr_ram_ff", 64'(perr_ram_ff), 64'(e_mon.ram_ff));
        check("perr_cnt",    64'(perr_cnt),    64'(e_mon.cnt));
        check("first_valid", 64'(first_valid), 64'(e_mon.fv));
        check("first_ram",   64'(first_ram),   64'(e_mon.fr));
      end
    end
  end

  initial begin
    logic [N-1:0] z;
    logic [N-1:0] one;
    logic [N-1:0] mask_r;
    logic [N-1:0] err_r;
    logic         rst_r;
    logic         pc_r;
    logic         wen_r;
    z   = '0;
    one = N'(1);

    // Reset.
    drive(1'b1, 1'b0, 1'b0, z, z);
    drive(1'b1, 1'b0, 1'b0, z, z);
    check("rst_perr_en",  64'(perr_en),     64'(0));
    check("rst_cnt",      64'(perr_cnt),    64'(0));
    check("rst_ram_ff",   64'(perr_ram_ff), 64'(0));
    check("rst_first_v",  64'(first_valid), 64'(0));

    // Error before arming: visible live, never recorded.
    drive(1'b0, 1'b0, 1'b0, one << 13, z);
    check("prearm_perr", 64'(perr),     64'(1));
    check("prearm_grp",  64'(perr_grp), 64'(7'b0000100));
    drive(1'b0, 1'b0, 1'b0, one << 13, z);
    check("prearm_pulse", 64'(perr_pulse),  64'(0));
    check("prearm_ram",   64'(perr_ram_ff), 64'(0));
    check("prearm_cnt",   64'(perr_cnt),    64'(0));

    // Arming: 7 writes, gap, 8 writes.
    repeat (7) drive(1'b0, 1'b0, 1'b1, z, z);
    drive(1'b0, 1'b0, 1'b0, z, z);
    check("arm_short_run", 64'(perr_en), 64'(0));
    repeat (7) drive(1'b0, 1'b0, 1'b1, z, z);
    check("arm_seven", 64'(perr_en), 64'(0));
    drive(1'b0, 1'b0, 1'b1, z, z);
    check("arm_eighth", 64'(perr_en), 64'(1));

    // Armed errors: {20,5} then {3}.
    drive(1'b0, 1'b0, 1'b0, (one << 20) | (one << 5), z);
    drive(1'b0, 1'b0, 1'b0, one << 3, z);
    drive(1'b0, 1'b0, 1'b0, z, z);
    check("t3_first_ram", 64'(first_ram),   64'(5));
    check("t3_first_v",   64'(first_valid), 64'(1));
    check("t3_ram_ff",    64'(perr_ram_ff), 64'((one << 20) | (one << 5) | (one << 3)));
    check("t3_grp_ff",    64'(perr_grp_ff), 64'(7'b0001001));
    check("t3_cnt",       64'(perr_cnt),    64'(2));

    // Masked RAM 7 ignored; unmasking with the error held latches it next edge.
    drive(1'b0, 1'b0, 1'b0, one << 7, one << 7);
    drive(1'b0, 1'b0, 1'b0, one << 7, one << 7);
    check("mask_ram7",  64'(perr_ram_ff[7]), 64'(0));
    check("mask_cnt",   64'(perr_cnt),       64'(2));
    check("mask_pulse", 64'(perr_pulse),     64'(0));
    drive(1'b0, 1'b0, 1'b0, one << 7, z);
    check("unmask_ram7", 64'(perr_ram_ff[7]), 64'(1));
    check("unmask_cnt",  64'(perr_cnt),       64'(3));

    // Saturation.
    repeat (20) drive(1'b0, 1'b0, 1'b0, one << $urandom_range(0, N - 1), z);
    check("sat_cnt",       64'(perr_cnt),  64'(CMAX));
    check("sat_first_ram", 64'(first_ram), 64'(5));

    // Clear beats a simultaneous error; re-arm needs a full run.
    drive(1'b0, 1'b1, 1'b1, one, z);
    check("clr_ram_ff", 64'(perr_ram_ff), 64'(0));
    check("clr_grp_ff", 64'(perr_grp_ff), 64'(0));
    check("clr_ff",     64'(perr_ff),     64'(0));
    check("clr_cnt",    64'(perr_cnt),    64'(0));
    check("clr_first",  64'(first_valid), 64'(0));
    check("clr_en",     64'(perr_en),     64'(0));
    check("clr_pulse",  64'(perr_pulse),  64'(0));
    repeat (7) drive(1'b0, 1'b0, 1'b1, z, z);
    check("rearm_seven", 64'(perr_en), 64'(0));
    drive(1'b0, 1'b0, 1'b1, z, z);
    check("rearm_eighth", 64'(perr_en), 64'(1));

    // Random traffic with occasional clears and mask changes.
    mask_r = z;
    for (int c = 0; c < 500; c++) begin
      rst_r = ($urandom_range(0, 199) == 0);
      pc_r  = ($urandom_range(0, 89) == 0);
      wen_r = ($urandom_range(0, 11) != 0);
      err_r = ($urandom_range(0, 2) == 0) ? (rnd_bits() & rnd_bits() & rnd_bits()) : z;
      if ($urandom_range(0, 15) == 0) mask_r = rnd_bits() & rnd_bits();
      drive(rst_r, pc_r, wen_r, err_r, mask_r);
    end

    drive(1'b0, 1'b0, 1'b0, z, z);
    repeat (2) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/parity_monitor.md
# parity_monitor

Parametrised RAM parity-error monitor for the TMB raw-hits path. Masks, summarises and latches per-RAM parity errors from `NGRP` CFEB groups of `NLY` layer RAMs. Arms itself only after the raw-hits FIFO has written every address. Adds a saturating error-cycle counter and first-error capture for VME readout and sequencer counting.

## Interface
Parameters:
- `NGRP`, 7, number of RAM groups (CFEBs)
- `NLY`, 6, RAMs per group (layers)
- `ARM_CNT`, 4096, consecutive FIFO writes required before arming
- `CNTW`, 16, width of the error-cycle counter

Ports:
- `clock`  in  1  40 MHz TMB main clock
- `reset`  in  1  synchronous, active-high; clears all state
- `perr_clear`  in  1  VME parity clear; same effect as `reset`
- `parity_err`  in  NGRP*NLY  raw per-RAM parity error; bit g*NLY+l = group g, layer l
- `ram_mask`  in  NGRP*NLY  1 = ignore that RAM
- `fifo_wen`  in  1  raw-hits FIFO write enable
- `perr_grp`  out  NGRP  combinational masked OR per group
- `perr`  out  1  combinational OR of `perr_grp`
- `perr_en`  out  1  monitor armed
- `perr_pulse`  out  1  registered `perr & perr_en`
- `perr_grp_ff`  out  NGRP  sticky per-group latch
- `perr_ff`  out  1  sticky summary latch
- `perr_ram_ff`  out  NGRP*NLY  sticky per-RAM map
- `perr_cnt`  out  CNTW  saturating count of armed error cycles
- `first_valid`  out  1  first-error capture valid
- `first_ram`  out  clog2(NGRP*NLY)  index of first erroring RAM

## Operation
- Masking: `merr = parity_err & ~ram_mask`. All outputs derive from `merr`.
- Clear condition: `clr = reset | perr_clear`.
- Arm counter:
  - Width clog2(ARM_CNT+1).
  - Increments on each `fifo_wen & ~perr_en` cycle.
  - Zeroes on any cycle without `fifo_wen`, or on `clr`.
- Arming:
  - `perr_en` sets on the edge where the counter already equals `ARM_CNT-1` and `fifo_wen` is high, i.e. the `ARM_CNT`-th consecutive write.
  - Counter then zeroes and holds while armed.
  - `perr_en` clears only on `clr`; re-arming requires a fresh `ARM_CNT` write run.
- Latches (`perr_ram_ff`, `perr_grp_ff`, `perr_ff`):
  - OR in current errors on each edge where registered `perr_en = 1` and `clr = 0`.
  - Hold otherwise.
  - Zero on `clr`.
- `perr_cnt`:
  - Increments when `perr & perr_en`.
  - Saturates at 2^CNTW-1 with no wrap.
  - Zero on `clr`.
- First-error capture:
  - On the first edge with `perr & perr_en & ~first_valid`: `first_ram` ← lowest set index of `merr` and `first_valid` ← 1.
  - Both hold until `clr`.
- Priority: `clr` beats arming, latching, counting and capture on the same edge.
- Reset values: `perr_en`, `perr_pulse`, all `_ff` outputs, `perr_cnt`, `first_valid` and `first_ram` are all 0. `perr_grp` and `perr` follow inputs combinationally.

## Timing
- `perr_grp`, `perr`: zero latency, combinational.
- `perr_pulse`, latches, `perr_cnt`, first capture: one cycle after the error cycle.
- An error in the same cycle `perr_en` first registers high is counted. An error on the arming edge itself is not.
- `clr` takes effect on the next edge. Outputs are 0 in the cycle after `clr`, even if errors persist.
- `fifo_wen` gap of one cycle at count `ARM_CNT-1` restarts arming from 0.
- Mask changes apply the same cycle. Already-latched bits stay set.

## Structure
- Package `parity_pkg`:
  - `clog2` function.
  - Default constants `PAR_NGRP`, `PAR_NLY`, `PAR_ARM_CNT`.
  - Helper to convert flat index to {group, layer}.
- One sub-module, `parity_arm`: arm counter plus `perr_en` flop. Inputs `clock`, `clr`, `fifo_wen`; output `perr_en`; parameter `ARM_CNT`.
- Top level holds masking, latches, counter and priority encoder. Encoder is a for-loop scanning from high to low index, so the lowest index wins.

## Test plan
Parameters for all tests: NGRP=7, NLY=6, ARM_CNT=8, CNTW=4.
1. Arming: 7 consecutive writes, gap, then 8 consecutive writes → `perr_en` stays 0 after the first run; rises the edge after the 8th write of the second run.
2. Pre-arm error: `parity_err` bit 13 high before arming → `perr`=1 and `perr_grp`=7'b0000100; `perr_pulse`, latches and `perr_cnt` remain 0.
3. Armed errors: bits 20 and 5 set in the same cycle, then bit 3 alone → `first_ram`=5 and `first_valid`=1. `perr_ram_ff` has bits 3, 5 and 20 set. `perr_grp_ff`=7'b0001001. `perr_cnt`=2. One `perr_pulse` per error cycle.
4. Saturation: 20 armed error cycles → `perr_cnt` holds at 15.
5. Mask: `ram_mask` bit 7 set, `parity_err` bit 7 pulsed while armed → no latch, count or pulse. Unmasking with the error still present latches bit 7 on the next edge.
6. Clear vs error: `perr_clear` in the same cycle as `parity_err` bit 0 → next cycle all sticky outputs are 0, `perr_en`=0, and re-arming requires 8 writes.
